// File: rtl/simon_core_param.sv
// Parametrised Simon game engine: fills a sequence RAM, replays a growing prefix
// on the LEDs, then checks the player's presses one at a time.
module simon_core_param #(
    parameter int          NUM_BTN       = 4,
    parameter int          MAX_ROUNDS    = 16,
    parameter int          RAND_SEQ      = 0,
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          SHOW_TICKS    = 2,
    parameter int          TIMEOUT_TICKS = 0,
    localparam int         BW            = $clog2(NUM_BTN),
    localparam int         RW            = $clog2(MAX_ROUNDS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] led,
    output logic               error_led,
    output logic               win_led,
    output logic [2:0]         fsm_state,
    output logic [RW-1:0]      round_cnt,
    output logic [RW-1:0]      input_idx
);

    localparam int AW = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
    localparam int SW = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;
    localparam int TW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;

    localparam logic [AW-1:0] LAST_FILL = AW'(MAX_ROUNDS - 1);
    localparam logic [SW-1:0] LAST_SHOW = SW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0] LAST_WAIT = TW'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);
    localparam logic [RW-1:0] ROUND_MAX = RW'(MAX_ROUNDS);
    localparam logic [RW-1:0] ONE       = RW'(1);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_ERROR = 3'd4,
        ST_WIN   = 3'd5
    } state_t;

    state_t             state, state_n;
    logic [RW-1:0]      round_n, idx_n;
    logic [NUM_BTN-1:0] led_n;
    logic               error_n, win_n;
    logic [AW-1:0]      fill_ptr, fill_n;
    logic [AW-1:0]      play_idx, play_n;
    logic [SW-1:0]      show_cnt, show_n;
    logic               gap, gap_n;
    logic [TW-1:0]      wait_cnt, wait_n;
    logic [NUM_BTN-1:0] press, press_n;
    logic [15:0]        lfsr, lfsr_n;
    logic [BW-1:0]      fill_val;

    logic [BW-1:0] seq_mem [MAX_ROUNDS];

    function automatic logic [NUM_BTN-1:0] onehot(input logic [BW-1:0] v);
        return NUM_BTN'(1) << v;
    endfunction

    assign fsm_state = state;

    // Galois form of x^16+x^14+x^13+x^11+1; free-running so each new game differs.
    assign lfsr_n = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    if (AW >= BW) begin : g_fill_trunc
        assign fill_val = fill_ptr[BW-1:0];
    end else begin : g_fill_ext
        assign fill_val = BW'(fill_ptr);
    end

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            seq_mem[fill_ptr] <= (RAND_SEQ != 0) ? lfsr[BW-1:0] : fill_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_INIT;
            round_cnt <= '0;
            input_idx <= '0;
            led       <= '0;
            error_led <= 1'b0;
            win_led   <= 1'b0;
            fill_ptr  <= '0;
            play_idx  <= '0;
            show_cnt  <= '0;
            gap       <= 1'b0;
            wait_cnt  <= '0;
            press     <= '0;
            lfsr      <= SEED;
        end else begin
            state     <= state_n;
            round_cnt <= round_n;
            input_idx <= idx_n;
            led       <= led_n;
            error_led <= error_n;
            win_led   <= win_n;
            fill_ptr  <= fill_n;
            play_idx  <= play_n;
            show_cnt  <= show_n;
            gap       <= gap_n;
            wait_cnt  <= wait_n;
            press     <= press_n;
            lfsr      <= lfsr_n;
        end
    end

    always_comb begin
        state_n = state;
        round_n = round_cnt;
        idx_n   = input_idx;
        fill_n  = fill_ptr;
        play_n  = play_idx;
        show_n  = show_cnt;
        gap_n   = gap;
        wait_n  = wait_cnt;
        press_n = press;

        case (state)
            ST_INIT: begin
                fill_n = fill_ptr + 1'b1;
                if (fill_ptr == LAST_FILL) begin
                    fill_n  = '0;
                    round_n = ONE;
                    idx_n   = '0;
                    play_n  = '0;
                    show_n  = '0;
                    gap_n   = 1'b0;
                    state_n = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (!gap) begin
                        if (show_cnt == LAST_SHOW) begin
                            gap_n  = 1'b1;
                            show_n = '0;
                        end else begin
                            show_n = show_cnt + 1'b1;
                        end
                    end else begin
                        gap_n = 1'b0;
                        if (RW'(play_idx) == round_cnt - ONE) begin
                            idx_n   = '0;
                            wait_n  = '0;
                            state_n = ST_WAIT;
                        end else begin
                            play_n = play_idx + 1'b1;
                        end
                    end
                end
            end
            ST_WAIT: begin
                // A press beats a timeout landing on the same clock.
                if (|btn_pulse) begin
                    press_n = btn_pulse;
                    state_n = ST_CHECK;
                end else if (TIMEOUT_TICKS > 0 && tick) begin
                    wait_n = wait_cnt + 1'b1;
                    if (wait_cnt == LAST_WAIT) begin
                        state_n = ST_ERROR;
                    end
                end
            end
            ST_CHECK: begin
                if (press != onehot(seq_mem[input_idx[AW-1:0]])) begin
                    state_n = ST_ERROR;
                end else if (input_idx != round_cnt - ONE) begin
                    idx_n   = input_idx + 1'b1;
                    wait_n  = '0;
                    state_n = ST_WAIT;
                end else if (round_cnt != ROUND_MAX) begin
                    round_n = round_cnt + 1'b1;
                    play_n  = '0;
                    show_n  = '0;
                    gap_n   = 1'b0;
                    state_n = ST_PLAY;
                end else begin
                    state_n = ST_WIN;
                end
            end
            ST_ERROR, ST_WIN: begin
                if (|btn_pulse) begin
                    round_n = '0;
                    fill_n  = '0;
                    state_n = ST_INIT;
                end
            end
            default: begin
                round_n = '0;
                fill_n  = '0;
                state_n = ST_INIT;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered LEDs line up with it.
    always_comb begin
        led_n   = '0;
        error_n = (state_n == ST_ERROR);
        win_n   = (state_n == ST_WIN);
        case (state_n)
            ST_PLAY:  led_n = gap_n ? '0 : onehot(seq_mem[play_n]);
            ST_CHECK: led_n = press_n;
            ST_WIN:   led_n = '1;
            default:  led_n = '0;
        endcase
    end

endmodule
